// File: rtl/mux_nto1_pipe_if.sv
// Handshake bundle for mux_nto1_pipe: NCH source channels, select control, one output stream.
// The master modport is the environment side, the slave modport is the selector itself.
interface mux_nto1_pipe_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
);
    logic [NCH*WIDTH-1:0] ch_data;
    logic [NCH-1:0]       ch_valid;
    logic [NCH-1:0]       ch_ready;
    logic                 rr_en;
    logic [SELW-1:0]      sel;
    logic                 sel_load;
    logic                 sel_err;
    logic [SELW-1:0]      cur_sel;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output ch_data, ch_valid, rr_en, sel, sel_load, out_ready,
        input  ch_ready, sel_err, cur_sel, out_data, out_valid
    );

    modport slave (
        input  ch_data, ch_valid, rr_en, sel, sel_load, out_ready,
        output ch_ready, sel_err, cur_sel, out_data, out_valid
    );
endinterface

// File: rtl/mux_nto1_pipe.sv
// Registered N-to-1 channel selector with fixed or round-robin grant and a
// 2-entry in-order output buffer that isolates ch_ready from out_ready.
module mux_nto1_pipe #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_nto1_pipe_if.slave bus
);
    localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef logic [SELW-1:0]  sel_t;
    typedef logic [WIDTH-1:0] data_t;

    sel_t       cur_sel_q, cur_sel_d;
    logic       sel_err_q, sel_err_d;
    data_t      buf_q [2];
    data_t      buf_d [2];
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;

    int         grant_i;
    logic       grant_vld;
    logic       full;
    logic       accept;
    logic       pop;
    data_t      grant_data;

    assign full = cnt_q[1];

    // Round-robin scans circularly starting at cur_sel; fixed mode always grants cur_sel.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int idx;
        idx       = 0;
        grant_i   = int'(cur_sel_q);
        grant_vld = !bus.rr_en;
        if (bus.rr_en) begin
            for (int k = 0; k < NCH; k++) begin
                idx = int'(cur_sel_q) + k;
                if (idx >= NCH) idx = idx - NCH;
                if (!grant_vld && bus.ch_valid[IW'(idx)]) begin
                    grant_vld = 1'b1;
                    grant_i   = idx;
                end
            end
        end
    end

    always_comb begin
        bus.ch_ready = '0;
        if (grant_vld && !full) bus.ch_ready[IW'(grant_i)] = 1'b1;
    end

    assign grant_data = bus.ch_data[grant_i*WIDTH +: WIDTH];
    assign accept     = grant_vld && !full && bus.ch_valid[IW'(grant_i)];
    assign pop        = (cnt_q != 2'd0) && bus.out_ready;

    // A valid sel_load wins over the round-robin advance; an out-of-range one only flags an error.
    always_comb begin
        cur_sel_d = cur_sel_q;
        sel_err_d = 1'b0;
        if (bus.sel_load && (int'(bus.sel) < NCH)) begin
            cur_sel_d = bus.sel;
        end else begin
            if (bus.sel_load) sel_err_d = 1'b1;
            if (bus.rr_en && accept) begin
                cur_sel_d = (grant_i + 1 == NCH) ? '0 : sel_t'(grant_i + 1);
            end
        end
    end

    always_comb begin
        buf_d  = buf_q;
        head_d = head_q ^ pop;
        tail_d = tail_q ^ accept;
        cnt_d  = cnt_q + {1'b0, accept} - {1'b0, pop};
        if (accept) buf_d[tail_q] = grant_data;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_sel_q <= '0;
            sel_err_q <= 1'b0;
            head_q    <= 1'b0;
            tail_q    <= 1'b0;
            cnt_q     <= 2'd0;
            // NOTE: the two buffer entries are reset because out_data exposes the head entry and must read 0 out of reset.
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
        end else begin
            cur_sel_q <= cur_sel_d;
            sel_err_q <= sel_err_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
        end
    end

    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = buf_q[head_q];
    assign bus.sel_err   = sel_err_q;
    assign bus.cur_sel   = cur_sel_q;
endmodule
